mod_up_cnt: RTL

MOD_UP_CNT -- requirements
Module: mod_up_cnt

---
 rtl/mod_up_cnt_pkg.sv | 14 +
 rtl/mod_up_cnt.sv | 117 +++++++++++
 2 files changed

// File: rtl/mod_up_cnt_pkg.sv
// rtl/mod_up_cnt_pkg.sv - shared types and constants for the modulo up-counter
package mod_up_cnt_pkg;

  // Default counter width in bits
  localparam int DEF_WIDTH = 4;

  // Counter control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_up_cnt.sv
// rtl/mod_up_cnt.sv - start/load controlled up-counter with limit, one-shot and wrap flag
module mod_up_cnt
  import mod_up_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic [WIDTH-1:0] r_limit_q;
  logic             r_mode_q;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_limit_nxt;
  logic             w_mode_nxt;
  logic             w_term;

  // Terminal also fires at all-ones so a load_val above the limit still wraps
  assign w_term = (r_count == r_limit_q) || (r_count == ALL_ONES);

  // Next-state decode: load beats start, start beats en; tc is a pulse so it defaults low
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_limit_nxt = r_limit_q;
    w_mode_nxt  = r_mode_q;
    if (load) begin
      w_count_nxt = load_val;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_limit_nxt = limit;
            w_mode_nxt  = oneshot;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (en) begin
            if (w_term) begin
              w_tc_nxt = 1'b1;
              if (r_mode_q) begin
                w_state_nxt = ST_DONE;
              end else begin
                w_count_nxt = '0;
                w_ovf_nxt   = 1'b1;
              end
            end else begin
              w_count_nxt = r_count + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            w_limit_nxt = limit;
            w_mode_nxt  = oneshot;
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_tc      <= 1'b0;
      r_ovf     <= 1'b0;
      r_limit_q <= ALL_ONES;
      r_mode_q  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_tc      <= w_tc_nxt;
      r_ovf     <= w_ovf_nxt;
      r_limit_q <= w_limit_nxt;
      r_mode_q  <= w_mode_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);

endmodule
